// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage load/store port (req/ack handshake).
// Latency: legal access acks LATENCY cycles after acceptance, rejected access acks after 1 cycle.
// Backpressure: stall_o holds the pipeline from acceptance until the ack cycle; inputs only sampled in IDLE.
// Ports: clk_i/rst_n_i clock and async active-low reset; req_i/we_i/addr_i/wdata_i request;
//        rdata_o/ack_o/err_o registered response; stall_o combinational pipeline hold.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [AW-1:0]   r_idx;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_ack;
    logic            r_err;
    logic [AW-1:0]   w_idx;
    logic            w_we;
    logic            w_illegal;
    logic [31:0]     r_mem [DEPTH_WORDS];

    // Any set bit above the word-index field means the word address is beyond the array.
    assign w_illegal = (addr_i[1:0] != 2'b00) || (|addr_i[31:AW+2]);

    // With LATENCY=1 the read happens on the acceptance edge, before the operands
    // are latched, so the live inputs are used while still in IDLE.
    assign w_idx = (r_state == IDLE) ? addr_i[AW+1:2] : r_idx;
    assign w_we  = (r_state == IDLE) ? we_i : r_we;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        stall_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    stall_o = 1'b1;
                    if (w_illegal) begin
                        w_next = ERR;
                    end else if (LATENCY == 1) begin
                        w_next = RESP;
                    end else begin
                        w_next     = BUSY;
                        w_cnt_next = CW'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            RESP:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && req_i) begin
                r_idx   <= addr_i[AW+1:2];
                r_we    <= we_i;
                r_wdata <= wdata_i;
            end
            // Response flags are registered one edge ahead so they line up with RESP/ERR.
            r_ack <= (w_next == RESP) || (w_next == ERR);
            r_err <= (w_next == ERR);
            if (w_next == RESP && !w_we) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Storage is not reset; a store commits on the edge that ends its ack cycle.
    always_ff @(posedge clk_i) begin
        if (r_state == RESP && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign rdata_o = r_rdata;
    assign ack_o   = r_ack;
    assign err_o   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wd, b_addr, b_wd;
    logic [31:0] a_rd, b_rd;
    logic        a_ack, a_err, a_stall, b_ack, b_err, b_stall;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(a_req), .we_i(a_we),
        .addr_i(a_addr), .wdata_i(a_wd), .rdata_o(a_rd), .ack_o(a_ack),
        .err_o(a_err), .stall_o(a_stall)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(b_req), .we_i(b_we),
        .addr_i(b_addr), .wdata_i(b_wd), .rdata_o(b_rd), .ack_o(b_ack),
        .err_o(b_err), .stall_o(b_stall)
    );

    task automatic drive(input logic s, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (s) begin
            b_req = req; b_we = we; b_addr = addr; b_wd = wd;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wd = wd;
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // One access: request in cycle T, per-cycle stall/ack/err check up to the ack
    // cycle, data check at ack. req stays high through the ack cycle.
    task automatic access(input logic s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_rd, input logic mutate,
                          input string nm);
        int lat;
        logic [2:0] obs, exp;
        logic [31:0] rd;
        lat = exp_err ? 1 : (s ? 1 : 3);
        @(posedge clk); #1;
        drive(s, 1'b1, we, addr, wd);
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (mutate && c == 1) drive(s, 1'b1, ~we, addr + 32'd4, ~wd);
            end
            @(negedge clk);
            obs = s ? {b_stall, b_ack, b_err} : {a_stall, a_ack, a_err};
            exp = {(c < lat), (c == lat), (exp_err && c == lat)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s T+%0d: stall/ack/err=%b required %b", nm, c, obs, exp);
            end
        end
        rd = s ? b_rd : a_rd;
        n_cmp++;
        if (rd !== exp_rd) begin
            n_bad++;
            $display("FAIL %s rdata: got %h required %h", nm, rd, exp_rd);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({a_ack, a_err, a_stall, a_rd} !== 35'd0 || {b_ack, b_err, b_stall, b_rd} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_state: a=%b%b%b %h b=%b%b%b %h required all zero",
                     a_ack, a_err, a_stall, a_rd, b_ack, b_err, b_stall, b_rd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic preload_a();
        access(0, 1, 32'h10, 32'h11111111, 0, 32'h0, 0, "pre10");
        access(0, 1, 32'h00, 32'hA5A5A5A5, 0, 32'h0, 0, "pre00");
        access(0, 1, 32'h08, 32'h88888888, 0, 32'h0, 0, "pre08");
        access(0, 1, 32'h0C, 32'hCCCCCCCC, 0, 32'h0, 0, "pre0C");
        go_idle();
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (a_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_busy_stall: got %b required 1", a_stall);
        end
        #1;
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        n_cmp++;
        if ({a_ack, a_err, a_stall, a_rd} !== 35'd0) begin
            n_bad++;
            $display("FAIL rst_busy_outputs: ack/err/stall=%b%b%b rdata=%h required zero",
                     a_ack, a_err, a_stall, a_rd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(0, 0, 32'h10, 32'h0, 0, 32'h11111111, 0, "rst_discard_load");
        go_idle();
    endtask

    task automatic test_misaligned();
        access(0, 0, 32'h22, 32'h0, 1, 32'h11111111, 0, "misaligned");
        go_idle();
    endtask

    task automatic test_store_load();
        access(0, 1, 32'h20, 32'h12345678, 0, 32'h11111111, 0, "store20");
        access(0, 0, 32'h20, 32'h0, 0, 32'h12345678, 0, "load20");
        go_idle();
    endtask

    task automatic test_out_of_range();
        access(0, 1, 32'h400, 32'hFFFFFFFF, 1, 32'h12345678, 0, "oor_store");
        access(0, 0, 32'h0, 32'h0, 0, 32'hA5A5A5A5, 0, "oor_alias_load");
        go_idle();
    endtask

    task automatic test_boundary();
        access(0, 1, 32'h3FC, 32'h5A5A5A5A, 0, 32'hA5A5A5A5, 0, "last_store");
        access(0, 0, 32'h3FC, 32'h0, 0, 32'h5A5A5A5A, 0, "last_load");
        access(0, 0, 32'h0, 32'h0, 0, 32'hA5A5A5A5, 0, "word0_intact");
        go_idle();
    endtask

    task automatic test_operand_change();
        access(0, 0, 32'h08, 32'h0, 0, 32'h88888888, 1, "busy_change");
        access(0, 0, 32'h0C, 32'h0, 0, 32'hCCCCCCCC, 0, "busy_no_write");
        go_idle();
    endtask

    task automatic test_back_to_back_lat1();
        access(1, 1, 32'h0, 32'h01010101, 0, 32'h0, 0, "b_pre0");
        access(1, 1, 32'h4, 32'h04040404, 0, 32'h0, 0, "b_pre4");
        go_idle();
        access(1, 0, 32'h0, 32'h0, 0, 32'h01010101, 0, "b2b_load0");
        access(1, 0, 32'h4, 32'h0, 0, 32'h04040404, 0, "b2b_load4");
        go_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        test_reset();
        preload_a();
        test_reset_mid_busy();
        test_misaligned();
        test_store_load();
        test_out_of_range();
        test_boundary();
        test_operand_change();
        test_back_to_back_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that serves the CPU's MEM-stage load/store port over a request/acknowledge handshake. It holds a word-organised RAM, answers each request after a fixed, parameterised latency, and drives a stall signal so the pipeline freezes while an access is outstanding. Misaligned and out-of-range accesses get an error response instead of touching storage. It sits between the CPU's EX/MEM register and the MEM/WB register.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words of storage; power of two, ≥4.
- LATENCY, 3: cycles from request acceptance to ack for a legal access; integer ≥1.

- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- req_i  input  1  access request; held high with operands stable through the ack cycle.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data.
- rdata_o  output  32  load data; registered.
- ack_o  output  1  one-cycle completion pulse; registered.
- err_o  output  1  qualifies ack_o: access rejected; registered.
- stall_o  output  1  pipeline hold request; combinational.

## Operation
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE, req_i=0: stay; stall_o=0.
- IDLE, req_i=1: latch addr_i, we_i, wdata_i; stall_o=1 this cycle.
  - Illegal (addr_i[1:0]≠0 or addr_i[31:2]≥DEPTH_WORDS) → ERR.
  - Legal, LATENCY=1 → RESP.
  - Legal, LATENCY>1 → BUSY, wait counter loaded with LATENCY−2.
- BUSY: stall_o=1; counter decrements; at 0 → RESP. Counter width $clog2(LATENCY) minimum 1 bit.
- RESP: ack_o=1, err_o=0, stall_o=0. Load: rdata_o = mem[addr[31:2]] in this cycle. Store: mem[addr[31:2]] ← wdata at the clock edge ending RESP; rdata_o unchanged. → IDLE.
- ERR: ack_o=1, err_o=1, stall_o=0; no memory write; rdata_o unchanged. → IDLE.
- Inputs are sampled only in IDLE; changes on req_i/operands while in BUSY/RESP/ERR are ignored.
- req_i high in the cycle after an ack is a new request (back-to-back accesses allowed, one per LATENCY+1 cycles).
- Reset (any state): FSM → IDLE, counter → 0, ack_o=0, err_o=0, rdata_o=0; pending store discarded, no ack issued. Memory array is not cleared by reset.

## Timing
- Request accepted in cycle T (IDLE, req_i=1). Legal access: ack_o high in cycle T+LATENCY exactly; error: ack_o high in cycle T+1.
- stall_o high in cycles T..T+LATENCY−1 (legal) or T only (error); low in the ack cycle, so the pipeline advances at the edge ending the ack cycle.
- ack_o, err_o never high for more than one consecutive cycle; err_o never high without ack_o.
- Store data is visible to a load accepted in any cycle after the store's ack.
- rdata_o valid only in a load ack cycle; holds its value otherwise.

## Test plan
- Reset: rst_n_i=0 mid-BUSY of a store 0x10←0xDEADBEEF → ack_o, err_o, rdata_o, stall_o all 0 next cycle; later load 0x10 returns old contents.
- Store then load, LATENCY=3: store 0x20←0x12345678 at T → stall_o high T..T+2, ack_o at T+3; load 0x20 at T+4 → ack_o at T+7, rdata_o=0x12345678.
- Misaligned: load 0x22 → ack_o=1, err_o=1 at T+1, stall_o high only at T, rdata_o unchanged.
- Out of range, DEPTH_WORDS=256: store 0x400←0xFFFFFFFF → err ack at T+1; load 0x0 afterwards returns its prior value (no aliasing write).
- LATENCY=1: back-to-back loads of 0x0 and 0x4 with req_i held high → acks at T+1 and T+3, correct data each, stall_o low only in ack cycles.
- Operand change during BUSY: addr_i switched from 0x8 to 0xC after acceptance → returned data is mem[2].
